// File: rtl/uart_frame_parser_if.sv
// Byte-level bus bundle for the UART frame parser:
// RX FIFO pop side plus the outgoing valid/ready payload stream.
interface uart_frame_parser_if;
    logic [7:0] rx_dout_i;
    logic       rx_empty_i;
    logic       rx_re_o;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_ready_i;
    logic       m_last_o;

    // Parser side: pops the FIFO and sources the payload stream.
    modport master (
        input  rx_dout_i,
        input  rx_empty_i,
        input  m_ready_i,
        output rx_re_o,
        output m_data_o,
        output m_valid_o,
        output m_last_o
    );

    // Environment side: the RX FIFO and the payload consumer.
    modport slave (
        output rx_dout_i,
        output rx_empty_i,
        output m_ready_i,
        input  rx_re_o,
        input  m_data_o,
        input  m_valid_o,
        input  m_last_o
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Frame decoder behind the UART RX FIFO: SOF, LEN, payload, CHK.
// Only frames whose modular sum is zero are replayed downstream.
module uart_frame_parser #(
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SOF            = 8'hA5,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    uart_frame_parser_if.master bus,
    output logic                frame_ok_o,
    output logic                chk_err_o,
    output logic                len_err_o,
    output logic                timeout_o,
    output logic                busy_o
);
    localparam int unsigned IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAXL = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_EMIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic [15:0] tmo_q, tmo_d;
    logic        pend_q, pend_d;
    logic        ok_q, ok_d;
    logic        cerr_q, cerr_d;
    logic        lerr_q, lerr_d;
    logic        tpul_q, tpul_d;
    logic        wr_en;
    logic        cap;
    logic        timed;
    logic        re;
    logic [7:0]  byte_w;
    logic [7:0]  mem_q [MAX_LEN];

    // A read issued last cycle means the FIFO data is valid now.
    assign cap    = pend_q;
    assign byte_w = bus.rx_dout_i;
    assign timed  = (state_q == S_LEN) || (state_q == S_PAYLOAD)
                 || (state_q == S_CHECK);

    // Pop only when idle on the read path and never while emitting.
    assign re = !rst_i && !bus.rx_empty_i && (state_q != S_EMIT)
             && !pend_q && !((state_q == S_CHECK) && cap);

    // Next-state, datapath updates and pulse requests.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        tmo_d   = '0;
        pend_d  = re;
        ok_d    = 1'b0;
        cerr_d  = 1'b0;
        lerr_d  = 1'b0;
        tpul_d  = 1'b0;
        wr_en   = 1'b0;
        if (timed) begin
            tmo_d = cap ? 16'd0 : tmo_q + 16'd1;
        end
        unique case (state_q)
            S_HUNT: begin
                if (cap && (byte_w == SOF)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (cap) begin
                    len_d = byte_w;
                    sum_d = byte_w;
                    if ((byte_w == 8'h00) || (byte_w > MAXL)) begin
                        lerr_d  = 1'b1;
                        state_d = S_HUNT;
                    end else begin
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (cap) begin
                    wr_en = 1'b1;
                    sum_d = sum_q + byte_w;
                    idx_d = idx_q + 8'd1;
                    if (idx_q + 8'd1 == len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (cap) begin
                    if (sum_q + byte_w == 8'h00) begin
                        ok_d    = 1'b1;
                        idx_d   = '0;
                        state_d = S_EMIT;
                    end else begin
                        cerr_d  = 1'b1;
                        state_d = S_HUNT;
                    end
                end
            end
            S_EMIT: begin
                if (bus.m_ready_i) begin
                    if (idx_q == len_q - 8'd1) begin
                        idx_d   = '0;
                        state_d = S_HUNT;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase
        // A stalled frame is abandoned; partial data is simply ignored.
        if ((TIMEOUT_CYCLES != 16'd0) && timed && !cap
            && (tmo_q == TIMEOUT_CYCLES - 16'd1)) begin
            tpul_d  = 1'b1;
            tmo_d   = '0;
            state_d = S_HUNT;
        end
    end

    // Control state, counters and registered pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_HUNT;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            tmo_q   <= '0;
            pend_q  <= 1'b0;
            ok_q    <= 1'b0;
            cerr_q  <= 1'b0;
            lerr_q  <= 1'b0;
            tpul_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            pend_q  <= pend_d;
            ok_q    <= ok_d;
            cerr_q  <= cerr_d;
            lerr_q  <= lerr_d;
            tpul_q  <= tpul_d;
        end
    end

    // Payload buffer; contents are only meaningful after a good CHK.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[idx_q[IW-1:0]] <= byte_w;
        end
    end

    assign bus.rx_re_o   = re;
    assign bus.m_valid_o = (state_q == S_EMIT);
    assign bus.m_data_o  = (state_q == S_EMIT) ? mem_q[idx_q[IW-1:0]] : 8'h00;
    assign bus.m_last_o  = (state_q == S_EMIT) && (idx_q == len_q - 8'd1);
    assign frame_ok_o    = ok_q;
    assign chk_err_o     = cerr_q;
    assign len_err_o     = lerr_q;
    assign timeout_o     = tpul_q;
    assign busy_o        = (state_q != S_HUNT);
endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: FIFO model feeds bytes,
// a scoreboard queue holds the payload bytes expected downstream.
module tb_uart_frame_parser;
    logic clk = 1'b0;
    logic rst;
    logic frame_ok, chk_err, len_err, tmo, busy;

    uart_frame_parser_if bus ();

    uart_frame_parser dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .frame_ok_o (frame_ok),
        .chk_err_o  (chk_err),
        .len_err_o  (len_err),
        .timeout_o  (tmo),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int         n_vec  = 0;
    int         n_miss = 0;
    int         cyc    = 0;
    int         pop_cyc = 0;
    int         to_cyc  = 0;
    int         n_ok, n_cerr, n_lerr, n_to, n_emit;
    int         emit_cyc[$];
    logic [7:0] fifo[$];
    logic [8:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        bus.rx_empty_i = 1'b0;
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic last);
        sb.push_back({last, d});
    endtask

    task automatic clear_cnt();
        n_ok   = 0;
        n_cerr = 0;
        n_lerr = 0;
        n_to   = 0;
        n_emit = 0;
        emit_cyc.delete();
    endtask

    // One clock: monitor at negedge, FIFO pop just after posedge.
    task automatic step();
        logic        re;
        logic [31:0] exp;
        @(negedge clk);
        re = bus.rx_re_o;
        if (bus.m_valid_o && bus.m_ready_i) begin
            n_emit++;
            emit_cyc.push_back(cyc);
            exp = (sb.size() != 0) ? {23'b0, sb.pop_front()} : 32'hFFFF_FFFF;
            chk("emit", {23'b0, bus.m_last_o, bus.m_data_o}, exp);
        end
        if (frame_ok) begin
            n_ok++;
            chk("ok_valid", {31'b0, bus.m_valid_o}, 32'd1);
        end
        if (chk_err) n_cerr++;
        if (len_err) n_lerr++;
        if (tmo) begin
            n_to++;
            to_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (re) begin
            bus.rx_dout_i = fifo.pop_front();
            pop_cyc = cyc;
        end
        bus.rx_empty_i = (fifo.size() == 0);
    endtask

    task automatic wait_idle(input int lim);
        int quiet;
        quiet = 0;
        for (int i = 0; i < lim; i++) begin
            step();
            if (fifo.size() == 0 && !busy && !bus.rx_re_o && sb.size() == 0)
                quiet++;
            else
                quiet = 0;
            if (quiet >= 3) break;
        end
        chk("idle_bound", quiet, 3);
    endtask

    task automatic counts(input string tag, input int ok, input int ce,
                          input int le, input int to, input int em);
        chk({tag, "_ok"}, n_ok, ok);
        chk({tag, "_chk_err"}, n_cerr, ce);
        chk({tag, "_len_err"}, n_lerr, le);
        chk({tag, "_timeout"}, n_to, to);
        chk({tag, "_emits"}, n_emit, em);
    endtask

    task automatic check_rst_outs(input string tag);
        chk(tag, {22'b0, bus.rx_re_o, bus.m_valid_o, bus.m_last_o,
                  frame_ok, chk_err, len_err, tmo, busy, bus.m_data_o}, 32'd0);
    endtask

    task automatic good_7f();
        push(8'hA5); push(8'h01); push(8'h7F); push(8'h80);
        expect_byte(8'h7F, 1'b1);
    endtask

    initial begin
        int gap;
        rst = 1'b1;
        bus.m_ready_i  = 1'b1;
        bus.rx_empty_i = 1'b1;
        bus.rx_dout_i  = 8'h00;
        clear_cnt();
        repeat (3) step();
        check_rst_outs("reset_outs");
        rst = 1'b0;

        // Good frame, three bytes back to back.
        clear_cnt();
        push(8'hA5); push(8'h03); push(8'h11);
        push(8'h22); push(8'h33); push(8'h97);
        expect_byte(8'h11, 1'b0);
        expect_byte(8'h22, 1'b0);
        expect_byte(8'h33, 1'b1);
        wait_idle(200);
        counts("good", 1, 0, 0, 0, 3);
        gap = (emit_cyc.size() == 3) ? emit_cyc[2] - emit_cyc[0] : -1;
        chk("good_gap", gap, 2);
        chk("good_busy", {31'b0, busy}, 32'd0);

        // Checksum error.
        clear_cnt();
        push(8'hA5); push(8'h03); push(8'h11);
        push(8'h22); push(8'h33); push(8'h98);
        wait_idle(200);
        counts("cerr", 0, 1, 0, 0, 0);

        // Garbage before SOF, SOF value used as CHK.
        clear_cnt();
        push(8'h00); push(8'hFF); push(8'hA5);
        push(8'h01); push(8'h5A); push(8'hA5);
        expect_byte(8'h5A, 1'b1);
        wait_idle(200);
        counts("garb", 1, 0, 0, 0, 1);

        // Zero and oversize LEN, then a good frame.
        clear_cnt();
        push(8'hA5); push(8'h00);
        push(8'hA5); push(8'h11);
        good_7f();
        wait_idle(200);
        counts("lenerr", 1, 0, 2, 0, 1);

        // Inter-byte timeout after the capture of 8'h10.
        clear_cnt();
        push(8'hA5); push(8'h02); push(8'h10);
        for (int i = 0; i < 2200 && n_to == 0; i++) step();
        chk("to_seen", n_to, 1);
        chk("to_delay", to_cyc - pop_cyc, 2001);
        wait_idle(50);
        counts("to", 0, 0, 0, 1, 0);
        clear_cnt();
        good_7f();
        wait_idle(200);
        counts("after_to", 1, 0, 0, 0, 1);

        // Backpressure in EMIT with more bytes waiting in the FIFO.
        clear_cnt();
        bus.m_ready_i = 1'b0;
        push(8'hA5); push(8'h02); push(8'h12);
        push(8'h34); push(8'hB8); push(8'h00);
        expect_byte(8'h12, 1'b0);
        expect_byte(8'h34, 1'b1);
        for (int i = 0; i < 60 && !bus.m_valid_o; i++) step();
        chk("bp_valid", {31'b0, bus.m_valid_o}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_data", {24'b0, bus.m_data_o}, 32'h12);
            chk("bp_re", {31'b0, bus.rx_re_o}, 32'd0);
        end
        bus.m_ready_i = 1'b1;
        wait_idle(200);
        counts("bp", 1, 0, 0, 0, 2);

        // Reset in the middle of a payload.
        clear_cnt();
        push(8'hA5); push(8'h04); push(8'h01); push(8'h02);
        repeat (12) step();
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        step();
        check_rst_outs("mid_rst_outs");
        rst = 1'b0;
        good_7f();
        wait_idle(200);
        counts("after_rst", 1, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
